// File: rtl/mem_stage.sv
// Memory stage: issues aligned loads/stores on a single-outstanding data bus,
// aligns load data / store lanes, and buffers one writeback entry.
module mem_stage #(
  parameter int XLEN           = 64,
  parameter bit DRAIN_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [1:0]      in_memop,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [1:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_misalign
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, OUT = 2'd2} state_t;

  state_t state_reg, state_next;

  logic            is_load, is_store, is_mem, misalign, mem_fault, bus_issue;
  logic            accept, bus_done;
  logic            stale_reg;
  logic            load_reg, unsigned_reg, wen_reg;
  logic [4:0]      rd_reg;
  logic [7:0]      strobe_base;
  logic [XLEN-1:0] shifted, load_value;

  logic            dreq_valid_reg;
  logic [XLEN-1:0] dreq_addr_reg, dreq_data_reg;
  logic [1:0]      dreq_size_reg;
  logic [7:0]      dreq_strobe_reg;
  logic            out_valid_reg, out_wen_reg, out_misalign_reg;
  logic [XLEN-1:0] out_result_reg;
  logic [4:0]      out_rd_reg;

  assign is_load   = (in_memop == 2'b01);
  assign is_store  = (in_memop == 2'b10);
  assign is_mem    = is_load || is_store;
  assign mem_fault = is_mem && misalign;
  assign accept    = in_valid && in_ready;
  assign bus_issue = accept && is_mem && !misalign;

  always_comb begin
    misalign = 1'b0;
    case (in_size)
      2'd1:    misalign = in_result[0];
      2'd2:    misalign = |in_result[1:0];
      2'd3:    misalign = |in_result[2:0];
      default: misalign = 1'b0;
    endcase
  end

  always_comb begin
    strobe_base = 8'h01;
    case (in_size)
      2'd0:    strobe_base = 8'h01;
      2'd1:    strobe_base = 8'h03;
      2'd2:    strobe_base = 8'h0F;
      default: strobe_base = 8'hFF;
    endcase
  end

  // Load data: bring the addressed lane down to bit 0, then extend by size.
  assign shifted = dresp_data >> {dreq_addr_reg[2:0], 3'b000};

  always_comb begin
    load_value = shifted;
    case (dreq_size_reg)
      2'd0:    load_value = {{(XLEN-8){~unsigned_reg & shifted[7]}}, shifted[7:0]};
      2'd1:    load_value = {{(XLEN-16){~unsigned_reg & shifted[15]}}, shifted[15:0]};
      2'd2:    load_value = {{(XLEN-32){~unsigned_reg & shifted[31]}}, shifted[31:0]};
      default: load_value = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus_issue) state_next = BUS;
      BUS:     if (bus_done)  state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    bus_done = 1'b0;
    case (state_reg)
      IDLE:    in_ready = reset && (!out_valid_reg || out_ready);
      BUS:     bus_done = dresp_data_ok && !stale_reg;
      default: ;
    endcase
  end

  // stale_reg masks any response the bus still owes from before reset,
  // until the bus has been seen quiet for a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stale_reg        <= DRAIN_ON_RESET;
      load_reg         <= 1'b0;
      unsigned_reg     <= 1'b0;
      wen_reg          <= 1'b0;
      rd_reg           <= '0;
      dreq_valid_reg   <= 1'b0;
      dreq_addr_reg    <= '0;
      dreq_size_reg    <= '0;
      dreq_strobe_reg  <= '0;
      dreq_data_reg    <= '0;
      out_valid_reg    <= 1'b0;
      out_result_reg   <= '0;
      out_rd_reg       <= '0;
      out_wen_reg      <= 1'b0;
      out_misalign_reg <= 1'b0;
    end else begin
      if (stale_reg && !dresp_addr_ok && !dresp_data_ok)
        stale_reg <= 1'b0;

      if (bus_issue) begin
        dreq_valid_reg  <= 1'b1;
        dreq_addr_reg   <= in_result;
        dreq_size_reg   <= in_size;
        dreq_strobe_reg <= is_store ? (strobe_base << in_result[2:0]) : 8'h00;
        dreq_data_reg   <= is_store ? (in_wdata << {in_result[2:0], 3'b000}) : '0;
        load_reg        <= is_load;
        unsigned_reg    <= in_unsigned;
        wen_reg         <= in_wen;
        rd_reg          <= in_rd;
      end else if (bus_done) begin
        dreq_valid_reg <= 1'b0;
      end

      if (accept && !bus_issue) begin
        out_valid_reg    <= 1'b1;
        out_result_reg   <= in_result;
        out_rd_reg       <= in_rd;
        out_wen_reg      <= in_wen && !is_mem;
        out_misalign_reg <= mem_fault;
      end else if (bus_done) begin
        out_valid_reg    <= 1'b1;
        out_result_reg   <= load_reg ? load_value : dreq_addr_reg;
        out_rd_reg       <= rd_reg;
        out_wen_reg      <= load_reg && wen_reg;
        out_misalign_reg <= 1'b0;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign dreq_valid   = dreq_valid_reg;
  assign dreq_addr    = dreq_addr_reg;
  assign dreq_size    = dreq_size_reg;
  assign dreq_strobe  = dreq_strobe_reg;
  assign dreq_data    = dreq_data_reg;
  assign out_valid    = out_valid_reg;
  assign out_result   = out_result_reg;
  assign out_rd       = out_rd_reg;
  assign out_wen      = out_wen_reg;
  assign out_misalign = out_misalign_reg;

endmodule
